univ_reg: RTL and testbench

Parametrised universal register for the ALU datapath; the next generation of the fixed 4-bit load register. Adds a W-bit width parameter, an opcode-driven mode set (hold, load, shift, rotate, increment, decrement) and multi-bit shifts that run one bit per cycle under a start/busy/done handshake. It sits between the ALU result bus and the operand/accumulator registers and drives a carry-out flag to the status logic.

---
 rtl/univ_reg_pkg.sv | 33 +++
 rtl/univ_reg_if.sv | 28 ++
 rtl/univ_reg_shift1.sv | 23 ++
 rtl/univ_reg.sv | 118 +++++++++++
 tb/tb_univ_reg.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/univ_reg_pkg.sv
// Shared types and helpers for the universal register: opcodes, FSM states, shift-direction decode.
package univ_reg_pkg;

    typedef enum logic [2:0] {
        OP_HOLD = 3'd0,
        OP_LOAD = 3'd1,
        OP_SHL  = 3'd2,
        OP_SHR  = 3'd3,
        OP_ROL  = 3'd4,
        OP_ROR  = 3'd5,
        OP_INC  = 3'd6,
        OP_DEC  = 3'd7
    } op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Bits move toward the MSB for SHL/ROL, toward the LSB otherwise.
    function automatic logic shift_left(op_e op);
        return (op == OP_SHL) || (op == OP_ROL);
    endfunction

    function automatic logic is_rotate(op_e op);
        return (op == OP_ROL) || (op == OP_ROR);
    endfunction

    function automatic logic is_shift_op(op_e op);
        return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROL) || (op == OP_ROR);
    endfunction

endpackage

// File: rtl/univ_reg_if.sv
// Request/result bundle between the ALU datapath and the universal register.
interface univ_reg_if #(
    parameter int unsigned W    = 8,
    parameter int unsigned SH_W = $clog2(W) + 1
);
    import univ_reg_pkg::*;

    logic            start;
    op_e             op;
    logic [SH_W-1:0] amt;
    logic            sin;
    logic [W-1:0]    in;
    logic [W-1:0]    out;
    logic            cout;
    logic            busy;
    logic            done;

    modport master (
        output start, op, amt, sin, in,
        input  out, cout, busy, done
    );

    modport slave (
        input  start, op, amt, sin, in,
        output out, cout, busy, done
    );

endinterface

// File: rtl/univ_reg_shift1.sv
// Combinational single-bit shift/rotate of a W-bit word; returns next word and the bit moved out.
module univ_reg_shift1
    import univ_reg_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] word,
    input  op_e          op,
    input  logic         sin,
    output logic [W-1:0] next_c,
    output logic         bit_c
);

    logic fill;

    // A rotate refills the vacated end with the very bit that left the other end.
    always_comb begin
        bit_c  = shift_left(op) ? word[W-1] : word[0];
        fill   = is_rotate(op) ? bit_c : sin;
        next_c = shift_left(op) ? {word[W-2:0], fill} : {fill, word[W-1:1]};
    end

endmodule

// File: rtl/univ_reg.sv
// Universal W-bit register: hold/load/shift/rotate/inc/dec with a start/busy/done handshake.
// Optional INC/DEC adder enabled by defining UNIV_REG_ARITH_EN; otherwise opcodes 6/7 act as HOLD.
module univ_reg
    import univ_reg_pkg::*;
#(
    parameter int unsigned W    = 8,
    parameter int unsigned SH_W = $clog2(W) + 1
) (
    input  logic       clk,
    input  logic       rst,
    univ_reg_if.slave  bus
);

    state_e          state_q, state_d;
    logic [W-1:0]    out_q, out_d;
    logic            cout_q, cout_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [SH_W-1:0] cnt_q, cnt_d;
    op_e             op_q, op_d;
    logic            sin_q, sin_d;
    logic [W-1:0]    sh_word_c;
    logic            sh_bit_c;

    univ_reg_shift1 #(.W(W)) u_shift1 (
        .word   (out_q),
        .op     (op_q),
        .sin    (sin_q),
        .next_c (sh_word_c),
        .bit_c  (sh_bit_c)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            out_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            op_q    <= OP_HOLD;
            sin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            sin_q   <= sin_d;
        end
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        cout_d  = cout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        op_d    = op_q;
        sin_d   = sin_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    done_d = 1'b1;
                    if (is_shift_op(bus.op)) begin
                        cout_d = 1'b0;
                        if (bus.amt != '0) begin
                            // Latch the request; the word only starts moving on the next edge.
                            cout_d  = cout_q;
                            done_d  = 1'b0;
                            busy_d  = 1'b1;
                            state_d = ST_SHIFT;
                            op_d    = bus.op;
                            sin_d   = bus.sin;
                            cnt_d   = (bus.amt > SH_W'(W)) ? SH_W'(W) : bus.amt;
                        end
                    end else begin
                        case (bus.op)
                            OP_LOAD: begin
                                out_d  = bus.in;
                                cout_d = 1'b0;
                            end
`ifdef UNIV_REG_ARITH_EN
                            OP_INC: {cout_d, out_d} = (W+1)'({1'b0, out_q}) + (W+1)'(1);
                            OP_DEC: begin
                                out_d  = out_q - W'(1);
                                cout_d = (out_q == '0);
                            end
`endif
                            default: ;
                        endcase
                    end
                end
            end
            ST_SHIFT: begin
                out_d  = sh_word_c;
                cout_d = sh_bit_c;
                cnt_d  = cnt_q - SH_W'(1);
                if (cnt_q == SH_W'(1)) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.out  = out_q;
    assign bus.cout = cout_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_univ_reg.sv
// Directed scoreboard bench for univ_reg (W=8); expectations are queued at issue and checked at done.
module tb_univ_reg;
    import univ_reg_pkg::*;

    localparam int unsigned W    = 8;
    localparam int unsigned SH_W = $clog2(W) + 1;

    typedef struct {
        logic [7:0] out;
        logic       cout;
        int         lat;
        string      tag;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst;
    int     cyc = 0;
    int     issue_cyc = 0;
    int     tests = 0;
    int     fails = 0;
    exp_t   sb[$];

    univ_reg_if #(.W(W), .SH_W(SH_W)) bus ();

    univ_reg #(.W(W), .SH_W(SH_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input string tag, input op_e op, input int amt, input logic sin,
                         input logic [7:0] din, input logic [7:0] e_out, input logic e_cout,
                         input int lat);
        bus.start = 1'b1;
        bus.op    = op;
        bus.amt   = SH_W'(amt);
        bus.sin   = sin;
        bus.in    = din;
        sb.push_back('{out: e_out, cout: e_cout, lat: lat, tag: tag});
        step();
        issue_cyc = cyc;
        bus.start = 1'b0;
    endtask

    task automatic finish_op(input bit trail);
        exp_t e;
        int   waited;
        waited = 0;
        e = sb.pop_front();
        while (bus.done !== 1'b1 && waited < 40) begin
            chk({e.tag, "_busy"}, 32'(bus.busy), 32'd1);
            step();
            waited++;
        end
        chk({e.tag, "_done"}, 32'(bus.done), 32'd1);
        chk({e.tag, "_lat"}, 32'(cyc - issue_cyc), 32'(e.lat));
        chk({e.tag, "_out"}, 32'(bus.out), 32'(e.out));
        chk({e.tag, "_cout"}, 32'(bus.cout), 32'(e.cout));
        chk({e.tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
        if (trail) begin
            step();
            chk({e.tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        end
    endtask

    initial begin
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.op    = OP_HOLD;
        bus.amt   = '0;
        bus.sin   = 1'b0;
        bus.in    = '0;
        step();
        step();
        chk("rst_out",  32'(bus.out),  32'h0);
        chk("rst_cout", 32'(bus.cout), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_done", 32'(bus.done), 32'h0);
        rst = 1'b1;
        step();

        // Reset in the middle of a shift, with a LOAD pending on start.
        issue("ld_ff", OP_LOAD, 0, 1'b0, 8'hFF, 8'hFF, 1'b0, 0);
        finish_op(1'b1);
        bus.start = 1'b1; bus.op = OP_SHL; bus.amt = SH_W'(5); bus.sin = 1'b0;
        step();
        bus.start = 1'b0;
        step();
        step();
        chk("mid_out",  32'(bus.out),  32'hFC);
        chk("mid_busy", 32'(bus.busy), 32'h1);
        rst = 1'b0;
        bus.start = 1'b1; bus.op = OP_LOAD; bus.in = 8'h77;
        step();
        rst = 1'b1;
        bus.start = 1'b0;
        chk("rst2_out",  32'(bus.out),  32'h0);
        chk("rst2_cout", 32'(bus.cout), 32'h0);
        chk("rst2_busy", 32'(bus.busy), 32'h0);
        chk("rst2_done", 32'(bus.done), 32'h0);
        issue("ld_a5", OP_LOAD, 0, 1'b0, 8'hA5, 8'hA5, 1'b0, 0);
        finish_op(1'b1);

        // SHL 3 with sin=1, checking every intermediate word.
        issue("ld_81", OP_LOAD, 0, 1'b0, 8'h81, 8'h81, 1'b0, 0);
        finish_op(1'b1);
        issue("shl3", OP_SHL, 3, 1'b1, 8'h00, 8'h0F, 1'b0, 3);
        chk("shl3_acc_out",  32'(bus.out),  32'h81);
        chk("shl3_acc_busy", 32'(bus.busy), 32'h1);
        chk("shl3_acc_done", 32'(bus.done), 32'h0);
        step();
        chk("shl3_m1_out",  32'(bus.out),  32'h03);
        chk("shl3_m1_cout", 32'(bus.cout), 32'h1);
        step();
        chk("shl3_m2_out", 32'(bus.out), 32'h07);
        finish_op(1'b1);

        // Rotate with clamped amount, then a single rotate and a HOLD.
        issue("ld_01", OP_LOAD, 0, 1'b0, 8'h01, 8'h01, 1'b0, 0);
        finish_op(1'b1);
        issue("ror9", OP_ROR, 9, 1'b1, 8'h00, 8'h01, 1'b0, 8);
        finish_op(1'b1);
        issue("ror1", OP_ROR, 1, 1'b0, 8'h00, 8'h80, 1'b1, 1);
        finish_op(1'b1);
        issue("hold", OP_HOLD, 0, 1'b0, 8'h12, 8'h80, 1'b1, 0);
        finish_op(1'b1);

        // Arithmetic ops, or HOLD behaviour when the adder is compiled out.
        issue("ld_ff2", OP_LOAD, 0, 1'b0, 8'hFF, 8'hFF, 1'b0, 0);
        finish_op(1'b1);
`ifdef UNIV_REG_ARITH_EN
        issue("inc", OP_INC, 0, 1'b0, 8'h00, 8'h00, 1'b1, 0);
        finish_op(1'b1);
        issue("dec", OP_DEC, 0, 1'b0, 8'h00, 8'hFF, 1'b1, 0);
        finish_op(1'b1);
`else
        issue("inc", OP_INC, 0, 1'b0, 8'h00, 8'hFF, 1'b0, 0);
        finish_op(1'b1);
        issue("dec", OP_DEC, 0, 1'b0, 8'h00, 8'hFF, 1'b0, 0);
        finish_op(1'b1);
`endif

        // LOAD held on start throughout a SHR: ignored until the first idle edge.
        issue("ld_9a", OP_LOAD, 0, 1'b0, 8'h9A, 8'h9A, 1'b0, 0);
        finish_op(1'b1);
        issue("shr4", OP_SHR, 4, 1'b1, 8'h00, 8'hF9, 1'b1, 4);
        bus.start = 1'b1; bus.op = OP_LOAD; bus.amt = '0; bus.in = 8'h3C;
        finish_op(1'b0);
        sb.push_back('{out: 8'h3C, cout: 1'b0, lat: 0, tag: "ld_3c_held"});
        step();
        issue_cyc = cyc;
        bus.start = 1'b0;
        finish_op(1'b1);

        // Back-to-back single-cycle ops.
        issue("b2b_1", OP_LOAD, 0, 1'b0, 8'h11, 8'h11, 1'b0, 0);
        finish_op(1'b0);
        issue("b2b_2", OP_LOAD, 0, 1'b0, 8'h22, 8'h22, 1'b0, 0);
        finish_op(1'b1);

        // Zero-amount shift clears cout and completes without busy.
        issue("ld_aa", OP_LOAD, 0, 1'b0, 8'hAA, 8'hAA, 1'b0, 0);
        finish_op(1'b1);
        issue("rol1", OP_ROL, 1, 1'b0, 8'h00, 8'h55, 1'b1, 1);
        finish_op(1'b1);
        issue("shl0", OP_SHL, 0, 1'b1, 8'h00, 8'h55, 1'b0, 0);
        finish_op(1'b1);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
